mem_responder: RTL and testbench
================================

# mem_responder

Word-addressed memory responder for the multicycle datapath. It sits on the memory side of the fetch/data path and answers read and write requests from the control unit. It supports a configurable number of wait states and signals completion with a single-cycle `ready` pulse. This gives the controller a real request/response handshake in place of fixed-timing reads.

## Interface
- `DATA_W`, default 32: data word width.
- `ADDR_W`, default 32: byte address width.
- `DEPTH`, default 256: number of words stored; power of two, ≥ 2.
- `WAIT`, default 2: wait-state cycles between acceptance and response; 0 allowed.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-high.
- `req`  in  1  request valid, level; sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `addr`  in  ADDR_W  byte address; bits [1:0] ignored; word index = `addr[ADDR_W-1:2]`.
- `wdata`  in  DATA_W  write data; sampled with `req`.
- `rdata`  out  DATA_W  registered read data.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high whenever state ≠ IDLE.
- `err`  out  1  error flag, valid with `ready` (only meaningful with the `MEM_RANGE_CHECK_EN` macro defined; see Configuration).

## Operation
- States and transitions:
  - IDLE:
    - If `req`=1, latch `we`, the word index and `wdata`, and load the wait counter with `WAIT`.
    - Go to WAIT if `WAIT`>0, else go to RESP.
  - WAIT:
    - Decrement the counter every cycle.
    - When the counter reaches 1 (decrement to 0), go to RESP.
  - RESP:
    - `ready`=1 for exactly this one cycle.
    - Unconditionally return to IDLE; `req` is ignored in RESP.
- Memory access happens on the clock edge that enters RESP:
  - Read: `rdata` ← mem[index].
  - Write: mem[index] ← latched `wdata`; `rdata` unchanged.
- `rdata` holds its value until the next read enters RESP.
- Requester protocol:
  - Hold `req`, `we`, `addr` and `wdata` stable until `ready` is seen.
  - Deassert `req` in the `ready` cycle, unless a new request is intended; a `req` still high in the following IDLE cycle is accepted as a new request.
- Memory array is not reset; contents are undefined until written.

## Timing
- Reset values:
  - state = IDLE, counter = 0.
  - `ready`=0, `busy`=0, `err`=0, `rdata`=0.
- Latency: `req` accepted in cycle 0 → `ready` in cycle `WAIT`+1. With `WAIT`=0, `ready` is in cycle 1.
- `busy` rises in cycle 1 and falls in the cycle after `ready`.
- Throughput: at most one request per `WAIT`+2 cycles.
- Reset mid-operation (in WAIT): the request is aborted with no write committed and no `ready` pulse. State returns to IDLE immediately.
- Reset asserted in RESP: the write has already committed and stays committed; `ready` drops asynchronously.
- Changes on `addr`, `we`, `wdata` or `req` during WAIT/RESP have no effect.

## Configuration
- `MEM_RANGE_CHECK_EN` defined:
  - Word index ≥ `DEPTH` (checked on the full latched index) sets `err`=1 in the `ready` cycle.
  - The write is suppressed and `rdata` is not updated.
  - `err`=0 in every other cycle.
- `MEM_RANGE_CHECK_EN` undefined:
  - Index wraps modulo `DEPTH` (low log2(`DEPTH`) bits used).
  - `err` is tied to 0.

## Test plan
- Write/read basic (`WAIT`=2): write 0xDEADBEEF to addr 0x10; `ready` in cycle 3 after acceptance. Then read 0x10 → `rdata`=0xDEADBEEF with `ready` in cycle 3, and `busy` high for cycles 1–3.
- Zero wait (`WAIT`=0): write 0x5 to addr 0x4, then read addr 0x4 → `ready` one cycle after each acceptance, `rdata`=0x5.
- Ignored low bits: write 0x1234 to addr 0x20; read addr 0x23 → `rdata`=0x1234.
- Held `req`: keep `req`=1 with `we`=0 through `ready` → a second read is accepted in the following IDLE cycle, and the second `ready` arrives exactly `WAIT`+2 cycles after the first.
- Reset mid-wait: issue a write of 0xAAAA to addr 0x8 (after it holds 0x1111), assert `rst_n` during WAIT. Expect no `ready`, `busy`=0 and `rdata`=0 immediately; a later read of 0x8 returns 0x1111.
- Range check (`DEPTH`=256, addr 0x400):
  - With `MEM_RANGE_CHECK_EN`: write sets `err`=1 with `ready`, and mem[0] is unchanged.
  - Without the macro: the write lands in mem[0], and a read of addr 0x0 returns the written value with `err`=0.

Source files
------------

// File: rtl/mem_responder.sv
// Word-addressed memory responder with WAIT wait states and a one-cycle ready pulse.
// Optional out-of-range detection is enabled by defining MEM_RANGE_CHECK_EN.
module mem_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int IW = ADDR_W - 2;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WAIT < 1) ? 1 : $clog2(WAIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_reg;
  logic [CW-1:0]     cnt_reg;
  logic              we_reg;
  logic [IW-1:0]     idx_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              ready_reg;
  logic              busy_reg;
  logic              err_reg;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc_we;
  logic [IW-1:0]     acc_idx;
  logic [DATA_W-1:0] acc_wdata;
  logic              enter_resp;
  logic              idx_ok;
  logic [AW-1:0]     mem_idx;
  logic              unused_bits;

  // With WAIT=0 the access happens on the acceptance edge, so the live
  // request fields must be used instead of the not-yet-latched copies.
  always_comb begin
    acc_we    = we_reg;
    acc_idx   = idx_reg;
    acc_wdata = wdata_reg;
    if (state_reg == S_IDLE) begin
      acc_we    = we;
      acc_idx   = addr[ADDR_W-1:2];
      acc_wdata = wdata;
    end
  end

  assign enter_resp = ((state_reg == S_IDLE) && req && (WAIT == 0)) ||
                      ((state_reg == S_WAIT) && (cnt_reg == CW'(1)));
  assign mem_idx    = acc_idx[AW-1:0];

`ifdef MEM_RANGE_CHECK_EN
  assign idx_ok      = (acc_idx < IW'(DEPTH));
  assign unused_bits = ^addr[1:0];
`else
  assign idx_ok      = 1'b1;
  assign unused_bits = ^{addr[1:0], acc_idx[IW-1:AW]};
`endif

  // Array kept free of reset so it maps onto block RAM; writes are blocked
  // while reset is held so an aborted request can never commit.
  always_ff @(posedge clk) begin
    if (!rst_n && enter_resp && acc_we && idx_ok) begin
      mem[mem_idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      idx_reg   <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      ready_reg <= enter_resp;
      err_reg   <= enter_resp && !idx_ok;
      if (enter_resp && !acc_we && idx_ok) begin
        rdata_reg <= mem[mem_idx];
      end
      case (state_reg)
        S_IDLE: begin
          if (req) begin
            we_reg    <= we;
            idx_reg   <= addr[ADDR_W-1:2];
            wdata_reg <= wdata;
            cnt_reg   <= CW'(WAIT);
            busy_reg  <= 1'b1;
            state_reg <= (WAIT == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            state_reg <= S_RESP;
          end
        end
        S_RESP: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign rdata = rdata_reg;
  assign ready = ready_reg;
  assign busy  = busy_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a WAIT=2 instance for most scenarios and a WAIT=0 instance.
module tb_mem_responder;

  localparam int WAIT_P = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, req0, we0;
  logic [31:0] addr, wdata, addr0, wdata0;
  logic [31:0] rdata, rdata0;
  logic        ready, busy, err, ready0, busy0, err0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model[int];
  logic [31:0] last_rdata;
  logic [31:0] last_rdata0;

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT(WAIT_P)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .busy(busy), .err(err)
  );

  mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  // Model the request and push its expected response before driving it.
  task automatic push_expect(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    int unsigned idx;
    bit          bad;
    idx = a >> 2;
`ifdef MEM_RANGE_CHECK_EN
    bad = (idx >= 256);
`else
    bad = 1'b0;
    idx = idx % 256;
`endif
    if (!bad && !w) last_rdata = model[idx];
    if (!bad && w) model[idx] = d;
    e.rdata = last_rdata;
    e.err   = bad;
    sb.push_back(e);
  endtask

  task automatic check_resp(input string name);
    exp_t e;
    e = sb.pop_front();
    checks++;
    if (rdata !== e.rdata) begin
      errors++;
      $display("FAIL %s_rdata: got %h expected %h", name, rdata, e.rdata);
    end
    checks++;
    if (err !== e.err) begin
      errors++;
      $display("FAIL %s_err: got %b expected %b", name, err, e.err);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy_resp: got %b expected 1", name, busy);
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input bit keep_req, input string name);
    int lat;
    push_expect(w, a, d);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    lat = 1;
    while (!ready && lat < 20) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_busy_wait: cycle %0d got %b expected 1", name, lat, busy);
      end
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!ready) begin
      errors++;
      void'(sb.pop_front());
      $display("FAIL %s_timeout: no ready after %0d cycles, expected %0d", name, lat, WAIT_P + 1);
    end else begin
      if (lat != WAIT_P + 1) begin
        errors++;
        $display("FAIL %s_latency: got %0d expected %0d", name, lat, WAIT_P + 1);
      end
      check_resp(name);
    end
    $display("txn %s we=%0b addr=%h wdata=%h rdata=%h err=%0b lat=%0d", name, w, a, d, rdata, err, lat);
    if (!keep_req) begin
      req = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_after: busy=%b ready=%b expected 0/0", name, busy, ready);
      end
    end
  endtask

  task automatic test_reset;
    checks++;
    if (rdata !== 32'h0 || ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdata=%h ready=%b busy=%b err=%b expected all 0", rdata, ready, busy, err);
    end
    checks++;
    if (rdata0 !== 32'h0 || ready0 !== 1'b0 || busy0 !== 1'b0 || err0 !== 1'b0) begin
      errors++;
      $display("FAIL reset0: rdata=%h ready=%b busy=%b err=%b expected all 0", rdata0, ready0, busy0, err0);
    end
    $display("txn reset done");
  endtask

  task automatic test_write_read;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "wr_basic");
    issue(1'b0, 32'h10, 32'h0, 1'b0, "rd_basic");
  endtask

  task automatic test_low_bits;
    issue(1'b1, 32'h20, 32'h1234, 1'b0, "wr_lowbits");
    issue(1'b0, 32'h23, 32'h0, 1'b0, "rd_lowbits");
  endtask

  task automatic test_held_req;
    int n;
    issue(1'b1, 32'h30, 32'h0BADF00D, 1'b0, "wr_held");
    issue(1'b0, 32'h30, 32'h0, 1'b1, "rd_held1");
    push_expect(1'b0, 32'h30, 32'h0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ready && n < 20);
    checks++;
    if (!ready || n != WAIT_P + 2) begin
      errors++;
      void'(sb.pop_front());
      $display("FAIL held_spacing: ready=%b after %0d cycles, expected 1 after %0d", ready, n, WAIT_P + 2);
    end else begin
      check_resp("rd_held2");
    end
    $display("txn rd_held2 spacing=%0d rdata=%h", n, rdata);
    req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL held_after: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, d;
    for (int i = 0; i < 4; i++) begin
      a = 32'h100 + 32'(i * 4);
      d = $urandom;
      issue(1'b1, a, d, 1'b0, "b2b_wr");
    end
    for (int i = 3; i >= 0; i--) begin
      a = 32'h100 + 32'(i * 4);
      issue(1'b0, a, 32'h0, 1'b0, "b2b_rd");
    end
  endtask

  task automatic test_zero_wait;
    logic [31:0] stim_a [2];
    logic        stim_w [2];
    stim_a[0] = 32'h4; stim_w[0] = 1'b1;
    stim_a[1] = 32'h4; stim_w[1] = 1'b0;
    last_rdata0 = 32'h0;
    for (int i = 0; i < 2; i++) begin
      if (!stim_w[i]) last_rdata0 = 32'h5;
      req0 = 1'b1; we0 = stim_w[i]; addr0 = stim_a[i]; wdata0 = 32'h5;
      @(posedge clk); #1;
      checks++;
      if (ready0 !== 1'b1 || busy0 !== 1'b1) begin
        errors++;
        $display("FAIL zw_latency: ready=%b busy=%b expected 1/1 one cycle after accept", ready0, busy0);
      end
      checks++;
      if (rdata0 !== last_rdata0 || err0 !== 1'b0) begin
        errors++;
        $display("FAIL zw_rdata: got %h err=%b expected %h err=0", rdata0, err0, last_rdata0);
      end
      $display("txn zero_wait we=%0b addr=%h rdata=%h", stim_w[i], stim_a[i], rdata0);
      req0 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy0 !== 1'b0 || ready0 !== 1'b0) begin
        errors++;
        $display("FAIL zw_after: busy=%b ready=%b expected 0/0", busy0, ready0);
      end
    end
  endtask

  task automatic test_reset_mid_wait;
    issue(1'b1, 32'h8, 32'h1111, 1'b0, "wr_pre");
    req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'hAAAA;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midwait_busy: got %b expected 1", busy);
    end
    rst_n = 1'b1;
    req   = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL midwait_reset: busy=%b ready=%b rdata=%h expected 0/0/0", busy, ready, rdata);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b0) begin
        errors++;
        $display("FAIL midwait_noready: got %b expected 0", ready);
      end
    end
    rst_n = 1'b0;
    last_rdata = 32'h0;
    $display("txn reset_mid_wait aborted write of AAAA to 0x8");
    @(posedge clk); #1;
    issue(1'b0, 32'h8, 32'h0, 1'b0, "rd_post_reset");
  endtask

  task automatic test_range;
    issue(1'b1, 32'h0, 32'h7777, 1'b0, "wr_mem0");
    issue(1'b1, 32'h400, 32'hCAFE, 1'b0, "wr_oor");
    issue(1'b0, 32'h0, 32'h0, 1'b0, "rd_mem0");
  endtask

  initial begin
    rst_n = 1'b1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    last_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    test_write_read();
    test_low_bits();
    test_held_req();
    test_back_to_back();
    test_zero_wait();
    test_reset_mid_wait();
    test_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
